sram22_rr_arbiter: RTL and testbench

- Shares one single-port sram22 macro (64 words x 4 bits, 2-bit write mask) between two requesters, A and B.
- Arbitration is round-robin. The block forwards the winning request to the macro and returns read data to the requester that issued the read.
- It sits between client logic and the macro instance. It owns every macro input pin except the power pins.

---
 rtl/sram22_rr_arbiter_if.sv | 49 ++++
 rtl/sram22_rr_arbiter.sv | 65 ++++++
 tb/tb_sram22_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram22_rr_arbiter_if.sv
// Bundle of the two requester ports and the macro pins of the sram22 round-robin arbiter.
// Handshake: a request transfers on a posedge where x_valid && x_ready; fields are held stable while x_valid && !x_ready.
interface sram22_rr_arbiter_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
);
  logic                   a_valid;
  logic                   a_ready;
  logic                   a_we;
  logic [WMASK_WIDTH-1:0] a_wmask;
  logic [ADDR_WIDTH-1:0]  a_addr;
  logic [DATA_WIDTH-1:0]  a_din;
  logic                   a_rsp_valid;
  logic [DATA_WIDTH-1:0]  a_rsp_data;

  logic                   b_valid;
  logic                   b_ready;
  logic                   b_we;
  logic [WMASK_WIDTH-1:0] b_wmask;
  logic [ADDR_WIDTH-1:0]  b_addr;
  logic [DATA_WIDTH-1:0]  b_din;
  logic                   b_rsp_valid;
  logic [DATA_WIDTH-1:0]  b_rsp_data;

  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport slave (
    input  a_valid, a_we, a_wmask, a_addr, a_din,
    output a_ready, a_rsp_valid, a_rsp_data,
    input  b_valid, b_we, b_wmask, b_addr, b_din,
    output b_ready, b_rsp_valid, b_rsp_data,
    output sram_we, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output a_valid, a_we, a_wmask, a_addr, a_din,
    input  a_ready, a_rsp_valid, a_rsp_data,
    output b_valid, b_we, b_wmask, b_addr, b_din,
    input  b_ready, b_rsp_valid, b_rsp_data,
    input  sram_we, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram22_rr_arbiter.sv
// Round-robin arbiter sharing one single-port sram22 macro between requesters A and B,
// routing each read response back to its issuer one cycle after the grant.
module sram22_rr_arbiter #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
) (
  input logic                clk,
  input logic                rst,
  sram22_rr_arbiter_if.slave bus
);
  logic                  prio;     // 0: A preferred, 1: B preferred
  logic [1:0]            rd_pend;  // bit0 = A, bit1 = B
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;
  logic                  grant_a;
  logic                  grant_b;

  always_comb begin
    grant_a = !rst && bus.a_valid && (!bus.b_valid || !prio);
    grant_b = !rst && bus.b_valid && (!bus.a_valid ||  prio);
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Idle cycles drive zeros so the macro only ever sees a write on a completed handshake.
  always_comb begin
    bus.sram_we    = 1'b0;
    bus.sram_wmask = '0;
    bus.sram_addr  = '0;
    bus.sram_din   = '0;
    if (grant_a) begin
      bus.sram_we    = bus.a_we;
      bus.sram_wmask = bus.a_wmask;
      bus.sram_addr  = bus.a_addr;
      bus.sram_din   = bus.a_din;
    end else if (grant_b) begin
      bus.sram_we    = bus.b_we;
      bus.sram_wmask = bus.b_wmask;
      bus.sram_addr  = bus.b_addr;
      bus.sram_din   = bus.b_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= 1'b0;
      rd_pend <= 2'b00;
      hold_a  <= '0;
      hold_b  <= '0;
    end else begin
      // The next preferred requester is the one that just lost (or did not ask).
      if (grant_a || grant_b) prio <= grant_a;
      rd_pend <= {grant_b && !bus.b_we, grant_a && !bus.a_we};
      if (rd_pend[0]) hold_a <= bus.sram_dout;
      if (rd_pend[1]) hold_b <= bus.sram_dout;
    end
  end

  assign bus.a_rsp_valid = rd_pend[0];
  assign bus.b_rsp_valid = rd_pend[1];
  assign bus.a_rsp_data  = rd_pend[0] ? bus.sram_dout : hold_a;
  assign bus.b_rsp_data  = rd_pend[1] ? bus.sram_dout : hold_b;
endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Bench for sram22_rr_arbiter: behavioural sram22 macro, a reference memory, and per-requester expected-data queues.
module tb_sram22_rr_arbiter;
  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  logic [3:0] mem     [64];
  logic [3:0] ref_mem [64];
  logic [3:0] exp_a_q [$];
  logic [3:0] exp_b_q [$];

  sram22_rr_arbiter_if #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) bus ();

  sram22_rr_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] merge(input logic [3:0] old_v, input logic [3:0] new_v,
                                       input logic [1:0] m);
    logic [3:0] r;
    r = old_v;
    for (int i = 0; i < 2; i++) if (m[i]) r[i*2 +: 2] = new_v[i*2 +: 2];
    return r;
  endfunction

  // sram22 macro model: samples at posedge, dout after the same edge, X after a write
  always @(posedge clk) begin
    if (bus.sram_we) begin
      mem[bus.sram_addr] = merge(mem[bus.sram_addr], bus.sram_din, bus.sram_wmask);
      bus.sram_dout <= 'x;
    end else begin
      bus.sram_dout <= mem[bus.sram_addr];
    end
  end

  // driver tasks
  task automatic drive_a(input logic v, input logic we, input logic [1:0] m,
                         input logic [5:0] addr, input logic [3:0] din);
    bus.a_valid = v; bus.a_we = we; bus.a_wmask = m; bus.a_addr = addr; bus.a_din = din;
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [1:0] m,
                         input logic [5:0] addr, input logic [3:0] din);
    bus.b_valid = v; bus.b_we = we; bus.b_wmask = m; bus.b_addr = addr; bus.b_din = din;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1, 1, 2'b11, 6'd1, 4'h1);
    drive_b(1, 1, 2'b11, 6'd2, 4'h2);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b0) $display("FAIL rst_a_ready got %b want 0", bus.a_ready); else passes++;
    checks++; if (bus.b_ready !== 1'b0) $display("FAIL rst_b_ready got %b want 0", bus.b_ready); else passes++;
    checks++; if (bus.sram_we !== 1'b0) $display("FAIL rst_sram_we got %b want 0", bus.sram_we); else passes++;
    checks++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
      $display("FAIL rst_rsp_valid got %b want 00", {bus.a_rsp_valid, bus.b_rsp_valid}); else passes++;
    checks++; if ({bus.a_rsp_data, bus.b_rsp_data} !== 8'h00)
      $display("FAIL rst_rsp_data got %h want 00", {bus.a_rsp_data, bus.b_rsp_data}); else passes++;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    drive_a(1, 1, 2'b11, 6'd5, 4'hA);
    ref_mem[5] = merge(ref_mem[5], 4'hA, 2'b11);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) $display("FAIL wr_a_ready got %b want 1", bus.a_ready); else passes++;
    checks++; if (bus.b_ready !== 1'b0) $display("FAIL wr_b_ready got %b want 0", bus.b_ready); else passes++;
    checks++; if ({bus.sram_we, bus.sram_addr, bus.sram_din} !== {1'b1, 6'd5, 4'hA})
      $display("FAIL wr_sram got we=%b addr=%0d din=%h want we=1 addr=5 din=a",
               bus.sram_we, bus.sram_addr, bus.sram_din); else passes++;
    next_cycle();
    drive_a(1, 0, 2'b00, 6'd5, 4'h0);
    exp_a_q.push_back(ref_mem[5]);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) $display("FAIL rd_a_ready got %b want 1", bus.a_ready); else passes++;
    checks++; if (bus.sram_we !== 1'b0) $display("FAIL rd_sram_we got %b want 0", bus.sram_we); else passes++;
    checks++; if (bus.a_rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got %b want 0", bus.a_rsp_valid); else passes++;
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.a_rsp_valid !== 1'b1) $display("FAIL rd_a_rsp_valid got %b want 1", bus.a_rsp_valid); else passes++;
    checks++; if (bus.b_rsp_valid !== 1'b0) $display("FAIL rd_b_rsp_valid got %b want 0", bus.b_rsp_valid); else passes++;
    begin
      logic [3:0] e;
      e = exp_a_q.pop_front();
      checks++; if (bus.a_rsp_data !== e) $display("FAIL rd_a_rsp_data got %h want %h", bus.a_rsp_data, e); else passes++;
    end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.a_rsp_valid !== 1'b0) $display("FAIL rd_pulse_width got %b want 0", bus.a_rsp_valid); else passes++;
    checks++; if (bus.a_rsp_data !== 4'hA) $display("FAIL rd_hold got %h want a", bus.a_rsp_data); else passes++;
    next_cycle();
  endtask

  task automatic test_alternate();
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % 2;
      if (k < 4) begin
        drive_a(1, 0, 0, 6'd1, 0);
        drive_b(1, 0, 0, 6'd2, 0);
        if (w == 0) exp_a_q.push_back(ref_mem[1]);
        else        exp_b_q.push_back(ref_mem[2]);
      end else begin
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
      end
      @(negedge clk);
      if (k < 4) begin
        checks++; if ({bus.a_ready, bus.b_ready} !== ((w == 0) ? 2'b10 : 2'b01))
          $display("FAIL alt_grant_%0d got a=%b b=%b want winner %s", k, bus.a_ready, bus.b_ready,
                   (w == 0) ? "A" : "B"); else passes++;
        checks++; if (bus.sram_addr !== ((w == 0) ? 6'd1 : 6'd2))
          $display("FAIL alt_addr_%0d got %0d want %0d", k, bus.sram_addr, (w == 0) ? 1 : 2); else passes++;
      end
      if (k > 0) begin
        int pw;
        logic [3:0] e;
        logic [3:0] got;
        pw = (k - 1) % 2;
        checks++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== ((pw == 0) ? 2'b10 : 2'b01))
          $display("FAIL alt_rsp_valid_%0d got a=%b b=%b want %s", k, bus.a_rsp_valid, bus.b_rsp_valid,
                   (pw == 0) ? "A" : "B"); else passes++;
        if (pw == 0) begin e = exp_a_q.pop_front(); got = bus.a_rsp_data; end
        else         begin e = exp_b_q.pop_front(); got = bus.b_rsp_data; end
        checks++; if (got !== e) $display("FAIL alt_rsp_data_%0d got %h want %h", k, got, e); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_partial_write();
    drive_b(1, 1, 2'b11, 6'd9, 4'hF);
    ref_mem[9] = merge(ref_mem[9], 4'hF, 2'b11);
    @(negedge clk);
    checks++; if (bus.b_ready !== 1'b1) $display("FAIL pw_full_ready got %b want 1", bus.b_ready); else passes++;
    next_cycle();
    drive_b(1, 1, 2'b01, 6'd9, 4'h0);
    ref_mem[9] = merge(ref_mem[9], 4'h0, 2'b01);
    @(negedge clk);
    checks++; if (bus.sram_wmask !== 2'b01) $display("FAIL pw_wmask got %b want 01", bus.sram_wmask); else passes++;
    next_cycle();
    drive_b(1, 0, 2'b00, 6'd9, 4'h0);
    exp_b_q.push_back(ref_mem[9]);
    @(negedge clk);
    checks++; if (bus.b_ready !== 1'b1) $display("FAIL pw_rd_ready got %b want 1", bus.b_ready); else passes++;
    next_cycle();
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    begin
      logic [3:0] e;
      e = exp_b_q.pop_front();
      checks++; if (bus.b_rsp_valid !== 1'b1) $display("FAIL pw_rsp_valid got %b want 1", bus.b_rsp_valid); else passes++;
      checks++; if (bus.b_rsp_data !== e) $display("FAIL pw_rsp_data got %h want %h", bus.b_rsp_data, e); else passes++;
      checks++; if (bus.b_rsp_data !== 4'hC) $display("FAIL pw_rsp_lit got %h want c", bus.b_rsp_data); else passes++;
    end
    next_cycle();
  endtask

  task automatic test_idle_hold();
    drive_a(1, 1, 2'b11, 6'd0, 4'h6);
    ref_mem[0] = 4'h6;
    next_cycle();
    drive_a(1, 1, 2'b11, 6'd3, 4'h5);
    ref_mem[3] = 4'h5;
    next_cycle();
    drive_a(1, 0, 2'b00, 6'd3, 4'h0);
    exp_a_q.push_back(ref_mem[3]);
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    begin
      logic [3:0] e;
      e = exp_a_q.pop_front();
      checks++; if (bus.a_rsp_data !== e) $display("FAIL idle_first_rsp got %h want %h", bus.a_rsp_data, e); else passes++;
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (bus.sram_we !== 1'b0) $display("FAIL idle_we_%0d got %b want 0", k, bus.sram_we); else passes++;
      checks++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
        $display("FAIL idle_rsp_valid_%0d got %b want 00", k, {bus.a_rsp_valid, bus.b_rsp_valid}); else passes++;
      checks++; if (bus.a_rsp_data !== 4'h5) $display("FAIL idle_hold_%0d got %h want 5", k, bus.a_rsp_data); else passes++;
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive_a(1, 0, 2'b00, 6'd5, 4'h0);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) $display("FAIL rmr_grant got %b want 1", bus.a_ready); else passes++;
    next_cycle();
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.a_rsp_valid !== 1'b0) $display("FAIL rmr_in_rst_valid got %b want 0", bus.a_rsp_valid); else passes++;
    checks++; if (bus.a_rsp_data !== 4'h0) $display("FAIL rmr_hold_clear got %h want 0", bus.a_rsp_data); else passes++;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive_a(1, 1, 2'b11, 6'd10, 4'h3);
    drive_b(1, 1, 2'b11, 6'd11, 4'h7);
    @(negedge clk);
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10)
      $display("FAIL rmr_prio got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); else passes++;
    checks++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
      $display("FAIL rmr_no_rsp got %b want 00", {bus.a_rsp_valid, bus.b_rsp_valid}); else passes++;
    ref_mem[10] = 4'h3;
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.b_ready !== 1'b1) $display("FAIL rmr_b_next got %b want 1", bus.b_ready); else passes++;
    ref_mem[11] = 4'h7;
    next_cycle();
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
      $display("FAIL rmr_wr_no_rsp got %b want 00", {bus.a_rsp_valid, bus.b_rsp_valid}); else passes++;
    next_cycle();
  endtask

  task automatic test_back_to_back_b_writes();
    int we_cycles;
    we_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        logic [3:0] d;
        d = 4'($urandom_range(0, 15));
        drive_b(1, 1, 2'b11, 6'(20 + k), d);
        ref_mem[20 + k] = d;
      end else begin
        drive_b(0, 0, 0, 0, 0);
      end
      @(negedge clk);
      if (bus.sram_we === 1'b1) we_cycles++;
      if (k < 3) begin
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b01)
          $display("FAIL b2b_ready_%0d got a=%b b=%b want a=0 b=1", k, bus.a_ready, bus.b_ready); else passes++;
      end
      next_cycle();
    end
    checks++; if (we_cycles != 3) $display("FAIL b2b_we_cycles got %0d want 3", we_cycles); else passes++;
    // read one back to confirm the burst landed
    drive_b(1, 0, 2'b00, 6'd21, 4'h0);
    exp_b_q.push_back(ref_mem[21]);
    next_cycle();
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    begin
      logic [3:0] e;
      e = exp_b_q.pop_front();
      checks++; if (bus.b_rsp_data !== e) $display("FAIL b2b_readback got %h want %h", bus.b_rsp_data, e); else passes++;
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 4'($urandom_range(0, 15));
      ref_mem[i] = mem[i];
    end
    next_cycle();
    test_reset();
    test_write_read();
    test_alternate();
    test_partial_write();
    test_idle_hold();
    test_reset_mid_read();
    test_back_to_back_b_writes();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
